// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for the bit-serial subtractor.
// The master side presents operands and consumes results; the slave side is
// the subtractor itself.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, zero
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and a registered borrow replace a ripple
// array. Operands enter on a valid/ready handshake and the result is held
// under a second valid/ready handshake until the consumer takes it.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;

   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             out_valid_q;

   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;
   logic             last;

   // Full-subtractor cell on the current LSBs plus the next result word.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      d        = sa[0] ^ sb[0] ^ br;
      br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      res_next = res >> 1;
      res_next[WIDTH-1] = d;
      last     = (cnt == CW'(WIDTH - 1));
   end

   // Control FSM, shift datapath and registered result outputs.
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         // NOTE: the shift registers are plain flops, so clearing them on reset is cheap and keeps outputs deterministic.
         state       <= IDLE;
         sa          <= '0;
         sb          <= '0;
         res         <= '0;
         br          <= 1'b0;
         cnt         <= '0;
         a_msb       <= 1'b0;
         b_msb       <= 1'b0;
         diff_q      <= '0;
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sa    <= bus.a;
                  sb    <= bus.b;
                  br    <= bus.bin;
                  a_msb <= bus.a[WIDTH-1];
                  b_msb <= bus.b[WIDTH-1];
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_next;
               res <= res_next;
               cnt <= cnt + CW'(1);
               if (last) begin
                  // The final cell output is the result MSB, so overflow
                  // and zero are resolved on the same edge as the word.
                  state       <= DONE;
                  diff_q      <= res_next;
                  bout_q      <= br_next;
                  ovf_q       <= (a_msb != b_msb) && (d != a_msb);
                  zero_q      <= (res_next == '0);
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed WIDTH=8 vectors,
// backpressure and mid-operation reset sequences, and exhaustive sweeps at
// WIDTH=4 and WIDTH=1 with random consumer stalls.
module tb_serial_subtractor;
   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(4)) bus4 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
      logic       zero;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Present operands on bus8 and wait for the result; returns edges from accept to out_valid.
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int n);
      bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      n = 0;
      while (!bus8.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic deliver8();
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      check("w8 out_valid drop", 32'(bus8.out_valid), 32'd0);
      check("w8 in_ready back", 32'(bus8.in_ready), 32'd1);
   endtask

   task automatic run4(input int a, input int b, input int bin);
      int n;
      int e;
      bus4.a = 4'(a); bus4.b = 4'(b); bus4.bin = bin[0]; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      n = 0;
      while (!bus4.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      e = a - b - bin;
      check("w4 latency", 32'(n), 32'd4);
      check("w4 bout,diff", {27'd0, bus4.bout, bus4.diff}, {27'd0, e < 0, 4'(e)});
      for (int k = 0; k < 4 && bus4.out_valid; k++) begin
         check("w4 in_ready excl", 32'(bus4.in_ready), 32'd0);
         bus4.out_ready = (k == 3) ? 1'b1 : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      bus4.out_ready = 1'b0;
      check("w4 taken", 32'(bus4.out_valid), 32'd0);
   endtask

   task automatic run1(input int a, input int b, input int bin);
      int n;
      int e;
      bus1.a = 1'(a); bus1.b = 1'(b); bus1.bin = bin[0]; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      n = 0;
      while (!bus1.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      e = a - b - bin;
      check("w1 latency", 32'(n), 32'd1);
      check("w1 bout,diff", {30'd0, bus1.bout, bus1.diff}, {30'd0, e < 0, 1'(e)});
      check("w1 in_ready excl", 32'(bus1.in_ready), 32'd0);
      bus1.out_ready = 1'($urandom_range(0, 1));
      if (!bus1.out_ready) begin
         @(posedge clk); #1;
         check("w1 hold", {30'd0, bus1.bout, bus1.diff}, {30'd0, e < 0, 1'(e)});
         bus1.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      check("w1 taken", 32'(bus1.out_valid), 32'd0);
   endtask

   initial begin
      int n;
      n_total = 0;
      n_pass  = 0;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};

      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0; bus8.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0; bus4.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0; bus1.out_ready = 1'b0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      check("rst in_ready", 32'(bus8.in_ready), 32'd1);
      check("rst out_valid", 32'(bus8.out_valid), 32'd0);
      check("rst diff", 32'(bus8.diff), 32'd0);
      check("rst flags", {29'd0, bus8.bout, bus8.ovf, bus8.zero}, 32'd0);

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         start8(vecs[i].a, vecs[i].b, vecs[i].bin, n);
         check("w8 latency", 32'(n), 32'd8);
         check("w8 diff", 32'(bus8.diff), 32'(vecs[i].diff));
         check("w8 bout", 32'(bus8.bout), 32'(vecs[i].bout));
         check("w8 ovf", 32'(bus8.ovf), 32'(vecs[i].ovf));
         check("w8 zero", 32'(bus8.zero), 32'(vecs[i].zero));
         check("w8 in_ready excl", 32'(bus8.in_ready), 32'd0);
         deliver8();
         check("w8 diff kept", 32'(bus8.diff), 32'(vecs[i].diff));
      end

      // Backpressure: result held, new operands ignored until IDLE is reached.
      start8(8'h05, 8'h03, 1'b0, n);
      check("bp latency", 32'(n), 32'd8);
      bus8.a = 8'h20; bus8.b = 8'h01; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp diff stable", 32'(bus8.diff), 32'h02);
         check("bp bout stable", 32'(bus8.bout), 32'd0);
         check("bp out_valid", 32'(bus8.out_valid), 32'd1);
         check("bp in_ready low", 32'(bus8.in_ready), 32'd0);
      end
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      check("bp in_ready after take", 32'(bus8.in_ready), 32'd1);
      check("bp out_valid after take", 32'(bus8.out_valid), 32'd0);
      // in_valid is still high, so the pending operands are taken now.
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      check("bp held operands taken", 32'(bus8.in_ready), 32'd0);
      n = 0;
      while (!bus8.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check("bp second latency", 32'(n), 32'd8);
      check("bp second diff", 32'(bus8.diff), 32'h1F);
      deliver8();

      // Reset during SHIFT discards the operation.
      bus8.a = 8'h55; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid rst out_valid", 32'(bus8.out_valid), 32'd0);
      check("mid rst in_ready", 32'(bus8.in_ready), 32'd1);
      check("mid rst diff", 32'(bus8.diff), 32'd0);
      start8(8'h09, 8'h04, 1'b0, n);
      check("post rst latency", 32'(n), 32'd8);
      check("post rst diff", 32'(bus8.diff), 32'h05);
      deliver8();

      // Exhaustive sweeps at the narrow widths.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               run4(a, b, c);
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < 2; c++)
               run1(a, b, c);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
